// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the execute stage: ALUOp, funct, forwarding selects, FSM states
package pipe_pkg;

    // ALUOp_i encodings from decode
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // {funct7,funct3} codes recognised for R-type
    localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
    localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
    localparam logic [9:0] FUNCT_AND = 10'b0000000_111;
    localparam logic [9:0] FUNCT_OR  = 10'b0000000_110;
    localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;

    // funct3 codes recognised for I-type
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;

    // forwarding selects; 2'b11 falls back to register data
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } ex_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX inputs, forwarding inputs and EX/MEM outputs of the execute stage
// master: pipeline side driving ID/EX and forwarding, observing EX/MEM and stall
// slave : ex_stage
interface ex_stage_if #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 10,
    parameter int REG_AW  = 5
);
    logic [1:0]         ALUOp_i;
    logic               ALUSrc_i;
    logic               RegWrite_i;
    logic               MemWrite_i;
    logic               MemRead_i;
    logic               Mem2Reg_i;
    logic [DATA_W-1:0]  RSdata_i;
    logic [DATA_W-1:0]  RTdata_i;
    logic [DATA_W-1:0]  imm_i;
    logic [FUNCT_W-1:0] funct_i;
    logic [REG_AW-1:0]  RDaddr_i;
    logic [1:0]         fwdA_i;
    logic [1:0]         fwdB_i;
    logic [DATA_W-1:0]  MEMfwd_i;
    logic [DATA_W-1:0]  WBfwd_i;

    logic               stall_o;
    logic [DATA_W-1:0]  ALUres_o;
    logic [DATA_W-1:0]  STdata_o;
    logic [REG_AW-1:0]  RDaddr_o;
    logic               RegWrite_o;
    logic               MemWrite_o;
    logic               MemRead_o;
    logic               Mem2Reg_o;

    modport master (
        output ALUOp_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i,
               RSdata_i, RTdata_i, imm_i, funct_i, RDaddr_i,
               fwdA_i, fwdB_i, MEMfwd_i, WBfwd_i,
        input  stall_o, ALUres_o, STdata_o, RDaddr_o,
               RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o
    );

    modport slave (
        input  ALUOp_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i,
               RSdata_i, RTdata_i, imm_i, funct_i, RDaddr_i,
               fwdA_i, fwdB_i, MEMfwd_i, WBfwd_i,
        output stall_o, ALUres_o, STdata_o, RDaddr_o,
               RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o
    );
endinterface

// File: rtl/ex_stage_iter_mul.sv
// rtl/ex_stage_iter_mul.sv - DATA_W-cycle shift-add multiplier, low DATA_W bits of a*b
// Ports: clk_i, rst_i (async active-low), start (latch a/b), a, b,
//        done (final step this cycle), product (accumulator including this cycle's step)
module iter_mul #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CW = $clog2(DATA_W);

    logic              busy;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] a_sh;
    logic [DATA_W-1:0] b_sh;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;

    // b_sh[0] is operand bit cnt; a_sh is a << cnt, truncated to the low word
    assign acc_next = b_sh[0] ? acc + a_sh : acc;
    assign done     = busy && (cnt == CW'(DATA_W - 1));
    // exposing the next value lets the last step land in EX/MEM at the same edge
    assign product  = acc_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy <= 1'b0;
            cnt  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            a_sh <= a;
            b_sh <= b;
            acc  <= '0;
        end else if (busy) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding muxes, ALU, iterative MUL with stall, EX/MEM register
// Ports: clk_i, rst_i (async active-low),
//        bus (ex_stage_if.slave): ID/EX controls/operands, forwarding values, EX/MEM outputs, stall_o
module ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 10,
    parameter int REG_AW  = 5
) (
    input logic       clk_i,
    input logic       rst_i,
    ex_stage_if.slave bus
);
    ex_state_t         state;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] b_fwd;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              is_mul;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    // EX/MEM register; ctrl packs {RegWrite, MemWrite, MemRead, Mem2Reg}
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] st_q;
    logic [REG_AW-1:0] rd_q;
    logic [3:0]        ctrl_q;

    // instruction fields captured when a MUL starts
    logic [DATA_W-1:0] lat_st;
    logic [REG_AW-1:0] lat_rd;
    logic [3:0]        lat_ctrl;

    always_comb begin
        case (bus.fwdA_i)
            FWD_WB:  op_a = bus.WBfwd_i;
            FWD_MEM: op_a = bus.MEMfwd_i;
            default: op_a = bus.RSdata_i;
        endcase
        case (bus.fwdB_i)
            FWD_WB:  b_fwd = bus.WBfwd_i;
            FWD_MEM: b_fwd = bus.MEMfwd_i;
            default: b_fwd = bus.RTdata_i;
        endcase
    end

    assign op_b   = bus.ALUSrc_i ? bus.imm_i : b_fwd;
    assign is_mul = (bus.ALUOp_i == ALUOP_RTYPE) && (bus.funct_i == FUNCT_W'(FUNCT_MUL));

    always_comb begin
        alu_res = op_a + op_b;
        case (bus.ALUOp_i)
            ALUOP_SUB: alu_res = op_a - op_b;
            ALUOP_RTYPE: begin
                if (bus.funct_i == FUNCT_W'(FUNCT_SUB)) begin
                    alu_res = op_a - op_b;
                end else if (bus.funct_i == FUNCT_W'(FUNCT_AND)) begin
                    alu_res = op_a & op_b;
                end else if (bus.funct_i == FUNCT_W'(FUNCT_OR)) begin
                    alu_res = op_a | op_b;
                end
            end
            ALUOP_ITYPE: begin
                if (bus.funct_i[2:0] == F3_AND) begin
                    alu_res = op_a & op_b;
                end else if (bus.funct_i[2:0] == F3_OR) begin
                    alu_res = op_a | op_b;
                end
            end
            default: ;
        endcase
    end

    assign mul_start = (state == ST_IDLE) && is_mul;

    // Gated by reset so the upstream hold is released the moment a MUL is aborted,
    // even though the MUL instruction may still be sitting in ID/EX.
    assign bus.stall_o = rst_i && (mul_start || ((state == ST_MUL) && !mul_done));

    iter_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (mul_start),
        .a       (op_a),
        .b       (b_fwd),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            res_q    <= '0;
            st_q     <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            lat_st   <= '0;
            lat_rd   <= '0;
            lat_ctrl <= '0;
        end else if (state == ST_IDLE) begin
            if (is_mul) begin
                state    <= ST_MUL;
                lat_st   <= b_fwd;
                lat_rd   <= bus.RDaddr_i;
                lat_ctrl <= {bus.RegWrite_i, bus.MemWrite_i, bus.MemRead_i, bus.Mem2Reg_i};
                ctrl_q   <= '0;
            end else begin
                res_q  <= alu_res;
                st_q   <= b_fwd;
                rd_q   <= bus.RDaddr_i;
                ctrl_q <= {bus.RegWrite_i, bus.MemWrite_i, bus.MemRead_i, bus.Mem2Reg_i};
            end
        end else begin
            if (mul_done) begin
                state  <= ST_IDLE;
                res_q  <= mul_product;
                st_q   <= lat_st;
                rd_q   <= lat_rd;
                ctrl_q <= lat_ctrl;
            end else begin
                ctrl_q <= '0;
            end
        end
    end

    assign bus.ALUres_o   = res_q;
    assign bus.STdata_o   = st_q;
    assign bus.RDaddr_o   = rd_q;
    assign bus.RegWrite_o = ctrl_q[3];
    assign bus.MemWrite_o = ctrl_q[2];
    assign bus.MemRead_o  = ctrl_q[1];
    assign bus.Mem2Reg_o  = ctrl_q[0];
endmodule
